irq_latch_arbiter: RTL and testbench
====================================

IRQ_LATCH_ARBITER -- requirements
Module: irq_latch_arbiter

Interface
REQ-001 clk  input  1  sole clock; all state updates on its rising edge.
REQ-002 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-003 req  input  8  raw request lines; bit i = source i; bit 7 highest priority.
REQ-004 mask  input  8  enable per source; 1 = enabled; applies at arbitration time only.
REQ-005 ready  input  1  consumer accepts the presented id when ready=1 and valid=1 on a rising edge.
REQ-006 valid  output  1  registered; an id is being presented.
REQ-007 Y  output  3  registered; index of the presented source, same encoding as the downstream 8:3 priority encoder (7 = bit 7).
REQ-008 pending  output  8  registered latched-request vector.
REQ-009 NONE  output  1  combinational; 1 when (pending & mask) == 0.

Function
REQ-010 Event vector ev is defined per REQ-030/031; pending_next = (pending & ~clr) | ev.
REQ-011 clr is one-hot at Y when valid=1 and ready=1 on that edge; otherwise zero.
REQ-012 If the same bit is set by ev and cleared by clr on one edge, set wins and the bit stays pending.
REQ-013 A second event on an already-pending bit merges; there is no count and no overflow flag.
REQ-014 The FSM has two states: IDLE (valid=0) and PRESENT (valid=1).
REQ-015 IDLE, (pending & mask) != 0: load Y with the index of the highest set bit of (pending & mask), then go to PRESENT.
REQ-016 IDLE, (pending & mask) == 0: stay in IDLE; Y holds its value.
REQ-017 In IDLE, arbitration uses the registered pending, so an event first arbitrates on the edge after it is latched.
REQ-018 PRESENT, ready=0: hold Y and valid=1 stable; do not re-arbitrate even if a higher-priority bit sets or mask changes.
REQ-019 PRESENT, ready=1: clear pending[Y] (subject to REQ-012), then go to IDLE; valid=0 for at least one cycle between grants.
REQ-020 Latency: with EDGE_DETECT_EN, req rising at edge k sets pending after k+1 and valid rises after k+2; without it, pending sets after k and valid rises after k+1.
REQ-021 Throughput: at most one grant per two cycles.
REQ-022 Masked pending bits are retained and arbitrate once unmasked.
REQ-023 NONE=1 and valid=1 may coexist when mask drops the presented bit during PRESENT; the grant still completes normally.

Reset
REQ-024 On an edge with reset=1, the block goes to IDLE with valid=0, Y=0, pending=0, and the edge-detect history register = 0.
REQ-025 Reset mid-PRESENT drops the grant without a handshake; req and ready on that edge are ignored.
REQ-026 The first edge after reset deasserts evaluates normally; a req line held high through reset produces an event only without EDGE_DETECT_EN.
REQ-027 NONE=1 immediately after reset.

Configuration
REQ-030 With IRQ_LATCH_ARBITER_EDGE_DETECT_EN defined: a register req_q tracks req each edge; ev = req & ~req_q (rising-edge events only); a held line produces one event.
REQ-031 Without it: ev = req (level-sensitive); a held line re-sets its pending bit every edge, so an accepted bit reappears while req stays high.

Verification
REQ-040 Reset, then req=8'h00, mask=8'hFF for 4 cycles -> valid=0, pending=8'h00, NONE=1, Y=0.
REQ-041 req=8'h24 pulsed one cycle, mask=8'hFF, ready=1 -> grant Y=5 then Y=2, each valid for one cycle, separated by a valid=0 cycle; pending ends at 8'h00.
REQ-042 Y=2 presented with ready=0, then req bit 7 pulses -> Y stays 2 until ready=1; the next grant is Y=7.
REQ-043 pending=8'h81, mask=8'h01 -> Y=0 granted; bit 7 remains pending; setting mask=8'hFF then gives Y=7.
REQ-044 Bit 3 presented, ready=1 while req[3] has a new event on the same edge -> pending[3] stays 1 and Y=3 is re-granted (edge mode: pulse req[3] low then high).
REQ-045 Reset asserted during PRESENT with pending=8'h10 -> on the next edge valid=0, pending=8'h00, Y=0; with EDGE_DETECT_EN, a req line held high across reset generates no event.

Source files
------------

// File: rtl/irq_latch_arbiter.sv
// irq_latch_arbiter
// Latches interrupt request events into a pending vector and presents one
// enabled source at a time through a valid/ready handshake. Sources are
// ranked by index, so bit 7 wins over every other source.
//
// Build option: define IRQ_LATCH_ARBITER_EDGE_DETECT_EN for rising-edge
// request detection. Without it, request lines are level-sensitive.
module irq_latch_arbiter (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req,
  input  logic [7:0] mask,
  input  logic       ready,
  output logic       valid,
  output logic [2:0] Y,
  output logic [7:0] pending,
  output logic       NONE
);

  localparam int DATA_W = 8;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] ev;
  logic [DATA_W-1:0] clr;
  logic [DATA_W-1:0] active;

  // Index of the highest set bit. Only called when at least one bit is set.
  function automatic logic [2:0] top_index(input logic [DATA_W-1:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < DATA_W; i++) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  assign active = pending & mask;
  assign NONE   = ~|active;

`ifdef IRQ_LATCH_ARBITER_EDGE_DETECT_EN
  logic [DATA_W-1:0] req_q;
  logic [DATA_W-1:0] ev_p1;

  // req_q follows req even while reset is held, so a line that stays high
  // across reset is seen as already high and yields no event afterwards.
  always_ff @(posedge clk) begin
    req_q <= req;
  end

  // Registered rising-edge events; this stage is the edge-detect history
  // and is cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) ev_p1 <= '0;
    else       ev_p1 <= req & ~req_q;
  end

  assign ev = ev_p1;
`else
  assign ev = req;
`endif

  // Accepted grant clears its own pending bit; nothing is cleared otherwise.
  always_comb begin
    clr = '0;
    if (valid && ready) clr[Y] = 1'b1;
  end

  // Pending latch: a new event on the same edge as its clear keeps the bit set.
  always_ff @(posedge clk) begin
    if (reset) pending <= '0;
    else       pending <= (pending & ~clr) | ev;
  end

  // Grant FSM: arbitrate from registered pending in IDLE, hold in PRESENT
  // until the consumer takes the id, then drop valid for at least one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      valid <= 1'b0;
      Y     <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (|active) begin
            Y     <= top_index(active);
            valid <= 1'b1;
            state <= PRESENT;
          end
        end
        PRESENT: begin
          if (ready) begin
            valid <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          valid <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_latch_arbiter.sv
// Self-checking bench for irq_latch_arbiter: directed scenarios with literal
// expectations, followed by randomized traffic checked every cycle against a
// behavioural model of the latch/grant rules.
module tb_irq_latch_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] req;
  logic [7:0] mask;
  logic       ready;
  logic       valid;
  logic [2:0] Y;
  logic [7:0] pending;
  logic       NONE;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model state: one flag per source, plus the presented grant.
  bit         m_pend [8];
  bit         m_valid;
  int         m_y;
  logic [7:0] m_reqq;
  logic [7:0] m_evq;

  irq_latch_arbiter dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .mask   (mask),
    .ready  (ready),
    .valid  (valid),
    .Y      (Y),
    .pending(pending),
    .NONE   (NONE)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic int pend_word();
    int w;
    w = 0;
    for (int i = 0; i < 8; i++) if (m_pend[i]) w += (1 << i);
    return w;
  endfunction

  // Highest-numbered source that is pending and enabled, or -1.
  function automatic int top_enabled();
    for (int i = 7; i >= 0; i--) if (m_pend[i] && mask[i]) return i;
    return -1;
  endfunction

  // Advance the model by one rising edge using the inputs sampled on it.
  task automatic model_edge();
    int         pick;
    int         acc;
    logic [7:0] evv;
    if (reset) begin
      for (int i = 0; i < 8; i++) m_pend[i] = 1'b0;
      m_valid = 1'b0;
      m_y     = 0;
      m_reqq  = req;
      m_evq   = 8'h00;
      return;
    end
    pick = top_enabled();
    acc  = (m_valid && ready) ? m_y : -1;
`ifdef IRQ_LATCH_ARBITER_EDGE_DETECT_EN
    evv    = m_evq;
    m_evq  = req & ~m_reqq;
    m_reqq = req;
`else
    evv = req;
`endif
    for (int i = 0; i < 8; i++) begin
      if (i == acc) m_pend[i] = 1'b0;
      if (evv[i])   m_pend[i] = 1'b1;
    end
    if (!m_valid) begin
      if (pick >= 0) begin
        m_y     = pick;
        m_valid = 1'b1;
      end
    end else if (ready) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic compare();
    check("valid",   valid,   m_valid);
    check("Y",       Y,       m_y);
    check("pending", pending, pend_word());
    check("NONE",    NONE,    ((pend_word() & mask) == 0));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic wait_valid(input string nm);
    for (int k = 0; k < 10; k++) begin
      if (valid === 1'b1) return;
      cycle();
    end
    n_vec++;
    n_err++;
    $display("FAIL %s: valid never rose, got %b expected 1", nm, valid);
  endtask

  initial begin
    reset = 1'b1;
    req   = 8'h00;
    mask  = 8'hFF;
    ready = 1'b0;
    cycle();
    cycle();
    reset = 1'b0;

    // Idle after reset
    repeat (4) cycle();
    check("idle_valid",   valid,   1'b0);
    check("idle_pending", pending, 8'h00);
    check("idle_none",    NONE,    1'b1);
    check("idle_y",       Y,       3'd0);

    // Two sources in one pulse, granted in priority order
    ready = 1'b1;
    req   = 8'h24;
    cycle();
    req = 8'h00;
    wait_valid("g5_wait");
    check("g5_y", Y, 3'd5);
    cycle();
    check("g5_gap", valid, 1'b0);
    wait_valid("g2_wait");
    check("g2_y", Y, 3'd2);
    cycle();
    check("g2_done_pending", pending, 8'h00);
    check("g2_done_valid",   valid,   1'b0);

    // Grant held while a higher-priority source arrives
    ready = 1'b0;
    req   = 8'h04;
    cycle();
    req = 8'h00;
    wait_valid("hold_wait");
    check("hold_y", Y, 3'd2);
    req = 8'h80;
    cycle();
    req = 8'h00;
    repeat (3) begin
      cycle();
      check("hold_y_stable", Y,     3'd2);
      check("hold_valid",    valid, 1'b1);
    end
    ready = 1'b1;
    cycle();
    check("hold_release_valid",   valid,   1'b0);
    check("hold_release_pending", pending, 8'h80);
    wait_valid("g7_wait");
    check("g7_y", Y, 3'd7);
    cycle();
    check("g7_done_pending", pending, 8'h00);

    // Masked source retained, then granted once enabled
    mask  = 8'h01;
    ready = 1'b0;
    req   = 8'h81;
    cycle();
    req = 8'h00;
    wait_valid("mask_wait");
    check("mask_y0", Y, 3'd0);
    ready = 1'b1;
    cycle();
    check("mask_gap",     valid,   1'b0);
    check("mask_pending", pending, 8'h80);
    repeat (2) cycle();
    check("mask_idle_valid", valid, 1'b0);
    check("mask_idle_none",  NONE,  1'b1);
    mask = 8'hFF;
    wait_valid("unmask_wait");
    check("unmask_y7", Y, 3'd7);
    cycle();
    check("unmask_done", pending, 8'h00);

    // New event on the accepting edge keeps the bit and re-grants it
    ready = 1'b0;
    req   = 8'h08;
    cycle();
    req = 8'h00;
    wait_valid("rg_wait");
    check("rg_y3", Y, 3'd3);
    cycle();
    req = 8'h08;
    cycle();
    ready = 1'b1;
    cycle();
    check("rg_setwins", pending & 8'h08, 8'h08);
    check("rg_gap",     valid,           1'b0);
    req   = 8'h00;
    ready = 1'b0;
    wait_valid("rg2_wait");
    check("rg2_y3", Y, 3'd3);
    ready = 1'b1;
    cycle();
    check("rg2_done", pending, 8'h00);

    // Reset in the middle of a grant, request held high across it
    ready = 1'b0;
    req   = 8'h10;
    cycle();
    wait_valid("rst_wait");
    check("rst_y4",      Y,       3'd4);
    check("rst_pending", pending, 8'h10);
    reset = 1'b1;
    cycle();
    check("rst_valid",   valid,   1'b0);
    check("rst_pend0",   pending, 8'h00);
    check("rst_y0",      Y,       3'd0);
    check("rst_none",    NONE,    1'b1);
    reset = 1'b0;
    cycle();
    cycle();
`ifdef IRQ_LATCH_ARBITER_EDGE_DETECT_EN
    check("rst_held_line", pending, 8'h00);
`else
    check("rst_held_line", pending, 8'h10);
`endif
    req   = 8'h00;
    ready = 1'b1;
    repeat (4) cycle();

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 2) == 0) req = 8'($urandom) & 8'($urandom);
      else if ($urandom_range(0, 1) == 0) req = 8'h00;
      if ($urandom_range(0, 9) == 0) mask = 8'($urandom) | 8'($urandom);
      ready = ($urandom_range(0, 2) != 0);
      cycle();
    end
    reset = 1'b0;
    req   = 8'h00;
    ready = 1'b1;
    repeat (4) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
